// File: rtl/spec_hc_add_pkg.sv
// Shared definitions for the speculative Han-Carlson adder controller.
//   state_t : controller FSM states (IDLE, SPEC, FIX, DONE)
//   DEF_W   : default operand width
//   DEF_K   : default speculation window (lower bits each speculative carry sees)
//   CNT_W   : width of the optional statistics counters
package spec_hc_add_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_K = 8;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spec_hc_add_ctrl_hc_prefix_tree.sv
// hc_prefix_tree: exact Han-Carlson carry network used on the FIX path.
// Ports:
//   a, b  (in, W)  addends
//   cin   (in, 1)  carry in
//   sum   (out, W) exact sum
//   cout  (out, 1) exact carry out
// Structure: black cells pair each odd bit with its even neighbour, a
// Kogge-Stone sparse tree (distances 2, 4, 8, ...) runs on odd bits only,
// and a final row of grey cells fills in the even-bit carries.
module hc_prefix_tree
  import spec_hc_add_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] gg;
  logic [W-1:0] pp;
  logic [W-1:0] ng;
  logic [W-1:0] np;
  logic [W:0]   carry;

  always_comb begin
    pp = a ^ b;
    gg = a & b;
    // Fold cin into bit 0 so every prefix group reaching bit 0 includes it.
    gg[0] = gg[0] | (pp[0] & cin);

    // Black cells: odd bit i absorbs bit i-1.
    ng = gg;
    np = pp;
    for (int i = 1; i < W; i += 2) begin
      ng[i] = gg[i] | (pp[i] & gg[i-1]);
      np[i] = pp[i] & pp[i-1];
    end
    gg = ng;
    pp = np;

    // Sparse Kogge-Stone on odd bits; odd bits with i <= d are already complete.
    for (int d = 2; d < W; d = d * 2) begin
      ng = gg;
      np = pp;
      for (int i = d + 1; i < W; i += 2) begin
        ng[i] = gg[i] | (pp[i] & gg[i-d]);
        np[i] = pp[i] & pp[i-d];
      end
      gg = ng;
      pp = np;
    end

    // Grey cells: even bits take the completed prefix from the odd bit below.
    // Even-bit gg/pp were never modified above, so they are still per-bit values.
    carry    = '0;
    carry[0] = cin;
    carry[1] = gg[0];
    for (int i = 1; i < W; i++) begin
      if (i % 2 == 1) carry[i+1] = gg[i];
      else            carry[i+1] = gg[i] | (pp[i] & gg[i-1]);
    end

    sum  = (a ^ b) ^ carry[W-1:0];
    cout = carry[W];
  end

endmodule

// File: rtl/spec_hc_add_ctrl.sv
// spec_hc_add_ctrl: variable-latency speculative Han-Carlson adder controller.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake; a, b (W), cin
//   out_valid / out_ready result handshake; sum (W), cout, corrected
//   op_count, fix_count   (32) only when SPEC_HC_ADD_STATS_EN is defined
//   fsm_state             (2) current controller state, for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge.
// SPEC evaluates windowed carries in one cycle; if the detector sees a run of
// K propagates (possible carry beyond the window) one extra FIX cycle uses
// the exact prefix tree. DONE doubles as the next accept cycle.
module spec_hc_add_ctrl
  import spec_hc_add_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int K = DEF_K
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic             cout,
  output logic             corrected,
`ifdef SPEC_HC_ADD_STATS_EN
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] fix_count,
`endif
  output logic [1:0]       fsm_state
);

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         cin_r;

  // Speculative path (inline) ------------------------------------------
  logic [W-1:0] p_r;
  logic [W-1:0] g_r;
  logic [W:0]   c_s;
  logic         err;
  logic         grp;
  logic         all_p;
  logic [W-1:0] spec_sum;
  logic         spec_cout;

  always_comb begin
    p_r      = a_r ^ b_r;
    g_r      = a_r & b_r;
    c_s      = '0;
    c_s[0]   = cin_r;
    err      = 1'b0;
    grp      = 1'b0;
    all_p    = 1'b0;
    // Low carries ripple exactly from cin.
    for (int i = 1; i <= K; i++) begin
      c_s[i] = g_r[i-1] | (p_r[i-1] & c_s[i-1]);
    end
    // High carries see only the K bits below, assuming carry-in 0 to the
    // window. If that whole window propagates, the assumption may be wrong.
    for (int i = K + 1; i <= W; i++) begin
      grp   = 1'b0;
      all_p = 1'b1;
      for (int j = i - K; j < i; j++) begin
        grp   = g_r[j] | (p_r[j] & grp);
        all_p = all_p & p_r[j];
      end
      c_s[i] = grp;
      if (all_p) err = 1'b1;
    end
    spec_sum  = p_r ^ c_s[W-1:0];
    spec_cout = c_s[W];
  end

  // Exact path ----------------------------------------------------------
  logic [W-1:0] tree_sum;
  logic         tree_cout;

  hc_prefix_tree #(.W(W)) u_tree (
    .a    (a_r),
    .b    (b_r),
    .cin  (cin_r),
    .sum  (tree_sum),
    .cout (tree_cout)
  );

  // Control -------------------------------------------------------------
  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      corrected <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            cin_r <= cin;
            state <= SPEC;
          end
        end
        SPEC: begin
          if (err) begin
            state <= FIX;
          end else begin
            sum       <= spec_sum;
            cout      <= spec_cout;
            corrected <= 1'b0;
            state     <= DONE;
          end
        end
        FIX: begin
          sum       <= tree_sum;
          cout      <= tree_cout;
          corrected <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              a_r   <= a;
              b_r   <= b;
              cin_r <= cin;
              state <= SPEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPEC_HC_ADD_STATS_EN
  // Saturating counters of completed results and of results from FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count  <= '0;
      fix_count <= '0;
    end else if (out_valid && out_ready) begin
      if (op_count != '1) op_count <= op_count + 1'b1;
      if (corrected && (fix_count != '1)) fix_count <= fix_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spec_hc_add_ctrl.sv
// Bench for spec_hc_add_ctrl: directed cases plus randomized operands and
// backpressure, checked against plain-arithmetic reference values.
module tb_spec_hc_add_ctrl;
  import spec_hc_add_pkg::*;

  localparam int W = 32;
  localparam int K = 8;

  // Clock / reset -----------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, cout, corrected;
  logic [1:0]   fsm_state;
`ifdef SPEC_HC_ADD_STATS_EN
  logic [31:0]  op_count, fix_count;
`endif

  spec_hc_add_ctrl #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .corrected (corrected),
`ifdef SPEC_HC_ADD_STATS_EN
    .op_count  (op_count),
    .fix_count (fix_count),
`endif
    .fsm_state (fsm_state)
  );

  // Checking ----------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model -----------------------------------------------------------
  // Mis-speculation is flagged when a run of K or more propagate bits lies
  // entirely within bits 1..W-1.
  function automatic logic model_err(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p;
    int run;
    p   = x ^ y;
    run = 0;
    for (int i = 1; i < W; i++) begin
      run = p[i] ? run + 1 : 0;
      if (run >= K) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W+1:0] model_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c);
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {model_err(x, y), full};
  endfunction

  // Scoreboard --------------------------------------------------------------
  logic [W+1:0] exp_q[$];   // {corrected, cout, sum}
  int           lat_q[$];
  int           acc_q[$];
  int           m_ops = 0;
  int           m_fix = 0;
  logic         ov_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
      m_ops   = 0;
      m_fix   = 0;
      ov_prev = 1'b0;
    end else begin
      if (out_valid) check_eq("in_ready_done", in_ready, out_ready);
      else           check_eq("in_ready_busy", in_ready, exp_q.size() == 0);
      if (out_valid && !ov_prev) begin
        if (lat_q.size() > 0) check_eq("latency", cyc - acc_q[0], lat_q[0]);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_valid", 1, 0);
        else                   check_eq("result", {corrected, cout, sum}, exp_q[0]);
      end
`ifdef SPEC_HC_ADD_STATS_EN
      check_eq("op_count", op_count, m_ops);
      check_eq("fix_count", fix_count, m_fix);
`endif
      if (out_valid && out_ready && exp_q.size() > 0) begin
        m_ops++;
        if (exp_q[0][W+1]) m_fix++;
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_result(a, b, cin));
        lat_q.push_back(model_err(a, b) ? 3 : 2);
        acc_q.push_back(cyc);
      end
      ov_prev = out_valid;
    end
  end

  // Driver tasks ------------------------------------------------------------
  // All drivers run at posedge+1 and return at posedge+1.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      output int acc);
    int t;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    cin      = tc;
    acc      = -1;
    t        = 0;
    while (acc < 0 && t < 50) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (acc < 0) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  logic rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Main sequence -----------------------------------------------------------
  int           acc0, acc1;
  int           t;
  logic [W-1:0] ra, rb;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_corrected", corrected, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases from the plan.
    send(32'h0000_0003, 32'h0000_0005, 1'b0, acc0);
    wait_done();
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, acc0);
    wait_done();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, acc0);
    wait_done();

    // Backpressure: hold the result for five cycles.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h0101_0101, 1'b0, acc0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("bp_valid_seen", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_complete", exp_q.size(), 0);

    // Back-to-back non-error ops: accepts every 2 cycles.
    acc1 = -1;
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      send(ra, rb, 1'($urandom_range(0, 1)), acc0);
      if (acc1 >= 0) check_eq("b2b_spacing", acc0 - acc1, 2);
      acc1 = acc0;
    end
    wait_done();

    // Reset while in FIX discards the op.
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, acc0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_state_fix", fsm_state, FIX);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_out_valid", out_valid, 0);
    check_eq("postrst_in_ready", in_ready, 1);
    check_eq("postrst_sum", sum, 0);
`ifdef SPEC_HC_ADD_STATS_EN
    check_eq("postrst_op_count", op_count, 0);
    check_eq("postrst_fix_count", fix_count, 0);
`endif
    @(posedge clk);
    #1;
    send(32'h0000_0010, 32'h0000_0020, 1'b1, acc0);
    wait_done();

    // Randomized operands with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = ~ra ^ (W'(1) << $urandom_range(0, W-1)); end
        2: begin ra = W'($urandom_range(0, 65535)); rb = W'($urandom_range(0, 65535)); end
        default: begin ra = $urandom; rb = ~ra; end
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)), acc0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spec_hc_add_ctrl.md
# spec_hc_add_ctrl

Sequencing controller for the speculative Han-Carlson adder. It accepts operands over a valid/ready handshake and evaluates a windowed (speculative) carry in one cycle. When the error detector flags a possible mis-speculation, it spends one extra cycle on the exact Han-Carlson prefix tree. The result is returned over a valid/ready handshake, which gives a variable-latency adder usable by any requester in the datapath.

## Interface
- `W`, 32, operand width (≥ 2·K)
- `K`, 8, speculation window: number of lower bits each speculative carry looks back over
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  controller can accept operands this cycle
- `a`, `b`  in  W  addends
- `cin`  in  1  carry in
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  W  result
- `cout`  out  1  carry out
- `corrected`  out  1  result came from the exact (FIX) path

## Operation
- Per bit: p=a^b, g=a&b; sum[i]=p[i]^c[i]; cout=c[W].
- Speculative carry c_s[i]:
  - i ≤ K: exact, including cin.
  - i > K: group generate of bits i-K..i-1 with carry-in 0.
- Error detect: err=1 if, for any i in K+1..W, p[i-K..i-1] are all 1. This detector is conservative. It never misses a real error, and a false flag costs only latency.
- FSM states are IDLE, SPEC, FIX and DONE.
  - IDLE: in_ready=1. On in_valid, register a, b, cin and go to SPEC.
  - SPEC: compute the speculative result and err from the registered operands. If err=0, register the speculative sum/cout with corrected=0 and go to DONE. If err=1, go to FIX.
  - FIX: register the exact-tree sum/cout with corrected=1 and go to DONE.
  - DONE: out_valid=1 and in_ready=out_ready.
    - out_ready=1 with in_valid=1: capture the new operands and go to SPEC.
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=0: hold.
- sum, cout and corrected are registered. They change only on the SPEC→DONE or FIX→DONE transition and are stable while out_valid=1 and out_ready=0.
- Operands are ignored whenever in_ready=0.

## Timing
- Reset (rst_n=0 at an edge) takes effect in any state, including mid-SPEC/FIX. It forces IDLE and discards the in-flight op.
- Reset values: in_ready=1; out_valid=0; sum=0; cout=0; corrected=0.
- Latency, with the operand accept handshake in cycle n:
  - err=0: out_valid first high in cycle n+2.
  - err=1: out_valid first high in cycle n+3.
- Throughput with out_ready held at 1 and in_valid held at 1 is one op per 2 cycles (no misses) or one per 3 cycles (misses), because the DONE cycle doubles as the next accept.
- There is no combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only in DONE.

## Configuration
- `SPEC_HC_ADD_STATS_EN`, when defined, adds two outputs:
  - `op_count` (out, 32): increments on each output handshake.
  - `fix_count` (out, 32): increments on each handshake with corrected=1.
  - Both saturate at 2^32-1 and are cleared by reset.
- When the macro is undefined, these ports and counters are absent. All other behaviour is identical.

## Structure
- Package `spec_hc_add_pkg` holds:
  - the FSM state enum (IDLE, SPEC, FIX, DONE);
  - default W and K constants;
  - the counter width constant.
- One sub-module, `hc_prefix_tree` (parameter W), builds the exact Han-Carlson carry network from black and grey cells for the FIX path. The windowed speculative carries and the error detector are written inline in the controller.

## Test plan
- a=0x00000003, b=0x00000005, cin=0, out_ready=1:
  - sum=0x00000008, cout=0, corrected=0.
  - out_valid in cycle n+2.
- a=0x0000FFFF, b=0x00000001, cin=0 (p has a 15-bit run):
  - FIX taken: sum=0x00010000, cout=0, corrected=1.
  - out_valid in cycle n+3.
- a=0xFFFFFFFF, b=0x00000000, cin=1:
  - err=1: sum=0x00000000, cout=1, corrected=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid:
  - sum/cout/corrected stable.
  - in_ready=0.
  - The op completes on the first out_ready=1.
- Back-to-back: in_valid and out_ready held at 1 with 4 non-error ops:
  - accepts every 2 cycles, results in order.
  - With STATS_EN: op_count=4, fix_count=0.
- rst_n=0 for one edge while in FIX:
  - next cycle out_valid=0, in_ready=1, sum=0.
  - With STATS_EN, counters=0.
  - The next op completes normally.
